// File: rtl/switch_debouncer_pkg.sv
// Shared DE0 I/O definitions and helpers for the slide-switch debouncer.
// Board-level constants live here so the top-level defaults track the board.
package switch_debouncer_pkg;

    localparam int SW_WIDTH           = 10;
    localparam int DEBOUNCE_1MS_50MHZ = 50000;

    // Action taken by one channel on a clock edge.
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_COUNT   = 2'd1,
        CH_ACCEPT  = 2'd2
    } ch_action_e;

    // Counter must hold values 0 .. stable_cycles-1 without wrapping.
    function automatic int debounce_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter and accept logic.
// Outputs are all registered; pending flags a non-zero counter.
module switch_debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEBOUNCE_1MS_50MHZ,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic changed,
    output logic pending
);

    localparam int CNT_W = debounce_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    (* async_reg = "true" *) logic sync1;
    (* async_reg = "true" *) logic sync2;

    logic [CNT_W-1:0] cnt;
    ch_action_e       action;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        action = CH_IDLE;
        if (sync2 != level) begin
            action = (cnt == CNT_LAST) ? CH_ACCEPT : CH_COUNT;
        end
    end

    // Any sample matching the current level restarts qualification.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            level   <= RESET_VAL;
            changed <= 1'b0;
            pending <= 1'b0;
        end else begin
            case (action)
                CH_ACCEPT: begin
                    level   <= sync2;
                    cnt     <= '0;
                    changed <= 1'b1;
                    pending <= 1'b0;
                end
                CH_COUNT: begin
                    cnt     <= cnt + CNT_W'(1);
                    changed <= 1'b0;
                    pending <= 1'b1;
                end
                default: begin
                    cnt     <= '0;
                    changed <= 1'b0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// DE0 slide-switch conditioner feeding the switch PIO in_port.
// One independent debounce channel per switch; busy reports any pending candidate.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int               WIDTH         = SW_WIDTH,
    parameter int               STABLE_CYCLES = DEBOUNCE_1MS_50MHZ,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             busy
);

    logic [WIDTH-1:0] pending;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        switch_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_in[i]),
            .level   (sw_out[i]),
            .changed (sw_changed[i]),
            .pending (pending[i])
        );
    end

    assign busy = |pending;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// checked against a sliding-window model of the debounce rule.
module tb_switch_debouncer;

    localparam int          W  = 10;
    localparam int          S  = 4;
    localparam logic [W-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = RV;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_changed;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S),
        .RESET_VAL     (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .sw_out     (sw_out),
        .sw_changed (sw_changed),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the level seen downstream is raw delayed two samples; a channel
    // flips when the last S of those samples all differ from its output.
    logic [W-1:0] m_s1, m_out, m_chg;
    logic         m_busy;
    logic [W-1:0] m_hist [S];

    task automatic model_reset();
        m_s1   = RV;
        m_out  = RV;
        m_chg  = '0;
        m_busy = 1'b0;
        for (int j = 0; j < S; j++) m_hist[j] = RV;
    endtask

    task automatic model_edge();
        logic [W-1:0] acc;
        logic [W-1:0] differ;
        acc = '1;
        for (int j = 0; j < S; j++) acc &= (m_hist[j] ^ m_out);
        differ = m_hist[0] ^ m_out;
        m_chg  = acc;
        m_busy = |(differ & ~acc);
        m_out  = m_out ^ acc;
        for (int j = S - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_s1;
        m_s1 = raw_in;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check("model_sw_out", sw_out, m_out);
        check("model_sw_changed", sw_changed, m_chg);
        check("model_busy", busy, m_busy);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int pulses;

        // 1: reset with all switches up, then release.
        model_reset();
        reset_n = 1'b0;
        raw_in  = 10'h3FF;
        #1;
        check("t1_rst_out", sw_out, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("t1_rst_out", sw_out, 0);
            check("t1_rst_chg", sw_changed, 0);
            check("t1_rst_busy", busy, 0);
        end
        reset_n = 1'b1;
        #1;
        check("t1_release_out", sw_out, 0);
        check("t1_release_chg", sw_changed, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (i < 6) begin
                check("t1_out_pre", sw_out, 0);
                check("t1_chg_pre", sw_changed, 0);
            end
            if (i == 5) check("t1_busy_pre", busy, 1);
            if (i == 6) begin
                check("t1_out", sw_out, 10'h3FF);
                check("t1_chg", sw_changed, 10'h3FF);
                check("t1_busy_drop", busy, 0);
            end
        end
        cycle();
        check("t1_chg_one_cycle", sw_changed, 0);
        raw_in = '0;
        idle(10);

        // 2: clean step on bit 0.
        raw_in[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check("t2_out0", sw_out[0], (i >= 6) ? 1 : 0);
            check("t2_chg0", sw_changed[0], (i == 6) ? 1 : 0);
            check("t2_busy", busy, (i >= 3 && i <= 5) ? 1 : 0);
        end

        // 3: bounce on bit 3.
        raw_in[3] = 1'b1;
        idle(3);
        raw_in[3] = 1'b0;
        idle(1);
        raw_in[3] = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (sw_changed[3]) pulses++;
            check("t3_out3", sw_out[3], (i >= 6) ? 1 : 0);
        end
        check("t3_pulses", pulses, 1);

        // 4: short glitch on bit 5.
        raw_in[5] = 1'b1;
        idle(2);
        raw_in[5] = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (sw_changed[5]) pulses++;
            check("t4_out5", sw_out[5], 0);
        end
        check("t4_pulses", pulses, 0);
        check("t4_busy", busy, 0);

        // 5: simultaneous steps on bits 1 and 9.
        raw_in[1] = 1'b1;
        raw_in[9] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            check("t5_chg", sw_changed, (i == 6) ? 10'h202 : 10'h000);
            check("t5_out", {sw_out[9], sw_out[1]}, (i >= 6) ? 2'b11 : 2'b00);
        end
        raw_in = '0;
        idle(10);

        // 6: reset while channel 2 is mid-qualification.
        raw_in[2] = 1'b1;
        idle(5);
        check("t6_busy_mid", busy, 1);
        reset_n = 1'b0;
        raw_in  = '0;
        model_reset();
        #1;
        check("t6_rst_out", sw_out, 0);
        check("t6_rst_busy", busy, 0);
        idle(2);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (sw_changed[2]) pulses++;
        end
        check("t6_pulses", pulses, 0);
        raw_in[2] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            check("t6_out2", sw_out[2], (i >= 6) ? 1 : 0);
            check("t6_chg2", sw_changed[2], (i == 6) ? 1 : 0);
        end

        // Random switch activity with slow and fast toggling phases.
        for (int c = 0; c < 3000; c++) begin
            int rate;
            rate = ((c / 200) % 2 == 0) ? 12 : 3;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, rate - 1) == 0) raw_in[b] = ~raw_in[b];
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_out", sw_out, RV);
            end else if (!reset_n) begin
                reset_n = 1'b1;
            end
            cycle();
        end
        reset_n = 1'b1;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
